// File: rtl/tmr_decoder_if.sv
// Handshake and status bundle for the TMR decoder.
// The slave side is the decoder; the master side is whoever feeds codewords,
// consumes decoded words and reads the error statistics.
interface tmr_decoder_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  // Ingress: triplicated codeword after the fault-injection point
  logic                  in_valid;
  logic                  in_ready;
  logic [3*DATA_W-1:0]   code_in;

  // Egress: voted word plus per-word correction status
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     data_out;
  logic [4:0]            flip_count;
  logic [2:0]            copy_fault;
  logic                  multi_fault;

  // Error statistics
  logic                  clear_stats;
  logic [CNT_W-1:0]      err_word_cnt;
  logic [CNT_W-1:0]      multi_cnt;

  modport slave (
    input  in_valid, code_in, out_ready, clear_stats,
    output in_ready, out_valid, data_out, flip_count, copy_fault, multi_fault,
           err_word_cnt, multi_cnt
  );

  modport master (
    output in_valid, code_in, out_ready, clear_stats,
    input  in_ready, out_valid, data_out, flip_count, copy_fault, multi_fault,
           err_word_cnt, multi_cnt
  );
endinterface

// File: rtl/tmr_decoder.sv
// TMR receive decoder: per-bit majority vote over three copies of a word,
// with correction status and saturating error statistics.
// Stage 1 captures the copies and their disagreement vector; stage 2 holds
// the voted word and its status. Both stages use a valid/ready skid-free
// handshake so the pipeline runs at one word per cycle and stalls cleanly.
module tmr_decoder #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  tmr_decoder_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1 state
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_c0, r_c1, r_c2;
  logic [DATA_W-1:0] r_dis;

  // Stage 2 state
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_data;
  logic [4:0]        r_flip;
  logic [2:0]        r_fault;
  logic              r_multi;

  // Statistics
  logic [CNT_W-1:0]  r_err_cnt;
  logic [CNT_W-1:0]  r_multi_cnt;

  // Combinational datapath and handshake
  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [DATA_W-1:0] w_c0, w_c1, w_c2;
  logic [DATA_W-1:0] w_dis;
  logic [DATA_W-1:0] w_vote;
  logic [4:0]        w_flip;
  logic [2:0]        w_fault;
  logic              w_multi;

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_s2_adv   = !r_s2_valid || bus.out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_in_xfer  = bus.in_valid && w_s1_adv;
  assign w_out_xfer = r_s2_valid && bus.out_ready;

  assign bus.in_ready = w_s1_adv;

  // Split the codeword; a bit disagrees unless all three copies match there.
  assign w_c0  = bus.code_in[DATA_W-1:0];
  assign w_c1  = bus.code_in[2*DATA_W-1:DATA_W];
  assign w_c2  = bus.code_in[3*DATA_W-1:2*DATA_W];
  assign w_dis = (w_c0 ^ w_c1) | (w_c1 ^ w_c2);

  // Stage 1 occupancy; a bubble loads when in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      // NOTE: state is always updated with <= so every flop samples pre-edge values.
      r_s1_valid <= bus.in_valid;
    end
  end

  // Stage 1 payload, loaded only with an accepted word.
  // NOTE: payload flops carry no reset; the valid flag alone qualifies them.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_c0  <= w_c0;
      r_c1  <= w_c1;
      r_c2  <= w_c2;
      r_dis <= w_dis;
    end
  end

  // Majority vote and per-copy fault attribution from stage 1 contents.
  always_comb begin
    // NOTE: defaults come first so no path through the block leaves a latch.
    w_flip = '0;
    for (int b = 0; b < DATA_W; b++) begin
      w_flip = w_flip + 5'(r_dis[b]);
    end
  end

  assign w_vote  = (r_c0 & r_c1) | (r_c0 & r_c2) | (r_c1 & r_c2);
  assign w_fault = {|(r_c2 ^ w_vote), |(r_c1 ^ w_vote), |(r_c0 ^ w_vote)};
  assign w_multi = (w_fault[0] & w_fault[1]) | (w_fault[0] & w_fault[2]) |
                   (w_fault[1] & w_fault[2]);

  // Stage 2: voted word and status; held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_data     <= '0;
      r_flip     <= '0;
      r_fault    <= '0;
      r_multi    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data  <= w_vote;
        r_flip  <= w_flip;
        r_fault <= w_fault;
        r_multi <= w_multi;
      end
    end
  end

  // Saturating statistics, counted on delivery; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt   <= '0;
      r_multi_cnt <= '0;
    end else if (bus.clear_stats) begin
      r_err_cnt   <= '0;
      r_multi_cnt <= '0;
    end else if (w_out_xfer) begin
      if ((r_flip != 5'd0) && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (r_multi && (r_multi_cnt != CNT_MAX)) begin
        r_multi_cnt <= r_multi_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid    = r_s2_valid;
  assign bus.data_out     = r_data;
  assign bus.flip_count   = r_flip;
  assign bus.copy_fault   = r_fault;
  assign bus.multi_fault  = r_multi;
  assign bus.err_word_cnt = r_err_cnt;
  assign bus.multi_cnt    = r_multi_cnt;

endmodule

// File: tb/tb_tmr_decoder.sv
// Self-checking bench for tmr_decoder: a reference vote model fills a
// scoreboard at each accepted word, and a negedge monitor compares every
// delivered word, the statistics counters and output stability under stall.
module tb_tmr_decoder;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [4:0]        flip;
    logic [2:0]        fault;
    logic              multi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tmr_decoder_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  tmr_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   m_err   = 0;
  int   m_multi = 0;
  logic held    = 1'b0;
  exp_t held_v;

  // Reference vote: counts ones per bit position across the three copies.
  function automatic exp_t model(input logic [3*DATA_W-1:0] code);
    exp_t e;
    int   ones;
    int   nf;
    e = '0;
    for (int b = 0; b < DATA_W; b++) begin
      ones = int'(code[b]) + int'(code[DATA_W+b]) + int'(code[2*DATA_W+b]);
      e.data[b] = (ones >= 2);
      if (ones == 1 || ones == 2) e.flip = e.flip + 5'd1;
    end
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < DATA_W; b++)
        if (code[i*DATA_W+b] != e.data[b]) e.fault[i] = 1'b1;
    nf = int'(e.fault[0]) + int'(e.fault[1]) + int'(e.fault[2]);
    e.multi = (nf > 1);
    return e;
  endfunction

  function automatic logic [3*DATA_W-1:0] tmr(input logic [DATA_W-1:0] w);
    return {w, w, w};
  endfunction

  // Monitor: reset behaviour, counters, stall stability and delivered words.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_err = 0; m_multi = 0; held = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.err_word_cnt !== '0 || bus.multi_cnt !== '0) begin
        errors++;
        $display("FAIL reset_hold: out_valid=%b err=%0d multi=%0d, need 0/0/0",
                 bus.out_valid, bus.err_word_cnt, bus.multi_cnt);
      end
    end else begin
      checks++;
      if (bus.err_word_cnt !== CNT_W'(m_err) || bus.multi_cnt !== CNT_W'(m_multi)) begin
        errors++;
        $display("FAIL counters: err=%0d multi=%0d, need %0d/%0d",
                 bus.err_word_cnt, bus.multi_cnt, m_err, m_multi);
      end
      if (held) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.data_out !== held_v.data ||
            bus.flip_count !== held_v.flip || bus.copy_fault !== held_v.fault ||
            bus.multi_fault !== held_v.multi) begin
          errors++;
          $display("FAIL stall_stable: valid=%b data=%h, need 1 data=%h",
                   bus.out_valid, bus.data_out, held_v.data);
        end
      end
      held = bus.out_valid && !bus.out_ready;
      held_v = {bus.data_out, bus.flip_count, bus.copy_fault, bus.multi_fault};
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: data=%h with empty scoreboard", bus.data_out);
        end else begin
          e = sb.pop_front();
          if (bus.data_out !== e.data || bus.flip_count !== e.flip ||
              bus.copy_fault !== e.fault || bus.multi_fault !== e.multi) begin
            errors++;
            $display("FAIL word: data=%h flip=%0d fault=%b multi=%b, need %h %0d %b %b",
                     bus.data_out, bus.flip_count, bus.copy_fault, bus.multi_fault,
                     e.data, e.flip, e.fault, e.multi);
          end
          if (bus.clear_stats) begin
            m_err = 0; m_multi = 0;
          end else begin
            if (e.flip != 0 && m_err < CMAX) m_err++;
            if (e.multi && m_multi < CMAX) m_multi++;
          end
        end
      end else if (bus.clear_stats) begin
        m_err = 0; m_multi = 0;
      end
    end
  end

  // Present one codeword until accepted; returns the cycles spent waiting.
  task automatic send(input logic [3*DATA_W-1:0] code, output int waits);
    waits = 0;
    bus.in_valid = 1'b1;
    bus.code_in  = code;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(code));
        break;
      end
      waits++;
      if (waits > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready=0 for %0d cycles, need 1", waits);
        bus.in_valid = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words undelivered, need 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== '0 || bus.flip_count !== '0 ||
        bus.copy_fault !== '0 || bus.multi_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h flip=%0d fault=%b multi=%b, need all 0",
               bus.out_valid, bus.data_out, bus.flip_count, bus.copy_fault, bus.multi_fault);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, need 1", bus.in_ready);
    end
  endtask

  task automatic test_clean();
    int w;
    int err0 = m_err;
    send(tmr(16'hA5C3), w);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b one cycle after accept, need 0", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 16'hA5C3 || bus.flip_count !== 5'd0 ||
        bus.copy_fault !== 3'b000) begin
      errors++;
      $display("FAIL clean_word: valid=%b data=%h flip=%0d fault=%b, need 1 a5c3 0 000",
               bus.out_valid, bus.data_out, bus.flip_count, bus.copy_fault);
    end
    drain("clean");
    checks++;
    if (int'(bus.err_word_cnt) != err0) begin
      errors++;
      $display("FAIL clean_err_cnt: got %0d, need %0d", bus.err_word_cnt, err0);
    end
  endtask

  task automatic test_faults();
    int w;
    logic [3*DATA_W-1:0] code;
    code = tmr(16'h1234);
    code[23] = ~code[23];
    send(code, w);
    code = tmr(16'h0F0F);
    code[0]  = ~code[0];
    code[47] = ~code[47];
    send(code, w);
    code = {16'hFFFF, 16'h0000, 16'hFF00};
    send(code, w);
    drain("faults");
    checks++;
    if (bus.err_word_cnt !== CNT_W'(3) || bus.multi_cnt !== CNT_W'(2)) begin
      errors++;
      $display("FAIL fault_counts: err=%0d multi=%0d, need 3/2",
               bus.err_word_cnt, bus.multi_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int total = 0;
    for (int i = 0; i < 6; i++) begin
      send(tmr(16'h1000 + 16'(i * 16'h0111)), w);
      total += w;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (total != 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL throughput: waits=%0d pending=%0d, need 0/0", total, sb.size());
    end
  endtask

  task automatic test_backpressure();
    int  total = 0;
    logic seen_stall = 1'b0;
    fork
      begin
        int w;
        for (int i = 0; i < 5; i++) begin
          send(tmr(16'hB000 + 16'(i)), w);
          total += w;
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (!bus.in_ready) seen_stall = 1'b1;
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("backpressure");
    checks++;
    if (!seen_stall || total == 0) begin
      errors++;
      $display("FAIL backpressure_stall: seen=%b waits=%0d, need 1 and >0", seen_stall, total);
    end
  endtask

  task automatic test_saturation();
    int w;
    logic [3*DATA_W-1:0] code;
    for (int i = 0; i < 17; i++) begin
      code = tmr(16'(i * 37));
      code[i % 16] = ~code[i % 16];
      send(code, w);
    end
    drain("saturation");
    checks++;
    if (bus.err_word_cnt !== CNT_W'(CMAX)) begin
      errors++;
      $display("FAIL err_saturate: got %0d, need %0d", bus.err_word_cnt, CMAX);
    end
    code = tmr(16'h5555);
    code[40] = ~code[40];
    send(code, w);
    @(posedge clk); #1;
    bus.clear_stats = 1'b1;
    @(posedge clk); #1;
    bus.clear_stats = 1'b0;
    checks++;
    if (bus.err_word_cnt !== '0 || bus.multi_cnt !== '0 || sb.size() != 0) begin
      errors++;
      $display("FAIL clear_wins: err=%0d multi=%0d pending=%0d, need 0/0/0",
               bus.err_word_cnt, bus.multi_cnt, sb.size());
    end
  endtask

  task automatic test_async_reset();
    int w;
    send(tmr(16'hC001), w);
    send(tmr(16'hC002), w);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b, need 0", bus.out_valid);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(tmr(16'hC003), w);
    drain("post_reset");
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.code_in     = '0;
    bus.out_ready   = 1'b1;
    bus.clear_stats = 1'b0;
    test_reset();
    test_clean();
    test_faults();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
